// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the instruction fetch sequencer and its
// PC sub-unit.
//
// Contents:
//   fetch_state_t   2-bit encoding of the fetch FSM (FETCH, WAIT, EXEC, HALT)
//   DEF_*           default values for the sequencer parameters
//   lat_cnt_width() width of a counter that must hold the values 0..mem_lat
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int          DEF_ADDR_W      = 32;
    localparam int          DEF_DATA_W      = 32;
    localparam int          DEF_INSTR_BYTES = 4;
    localparam int          DEF_MEM_LAT     = 1;
    localparam logic [31:0] DEF_RESET_ADDR  = 32'h0000_0000;

    // The latency counter must be able to hold the value mem_lat itself.
    function automatic int lat_cnt_width(input int mem_lat);
        return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// pc_unit -- combinational next-PC logic for the fetch sequencer.
//
// Ports:
//   pc        in   ADDR_W  current program counter
//   advance   in   1       step pc by INSTR_BYTES (wraps modulo 2^ADDR_W)
//   redirect  in   1       load an aligned copy of target (wins over advance)
//   target    in   ADDR_W  redirect address, may be misaligned
//   pc_next   out  ADDR_W  value to load into the pc register
module pc_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_next
);

    localparam int                ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] target_aligned;

    // Clear the byte-offset bits of the redirect address so every fetch is
    // instruction aligned. With INSTR_BYTES=1 nothing is cleared.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_align
            if (gi < ALIGN_BITS) begin : g_clear
                assign target_aligned[gi] = 1'b0;
            end else begin : g_keep
                assign target_aligned[gi] = target[gi];
            end
        end
    endgenerate

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target_aligned;
        end else if (advance) begin
            // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
            pc_next = pc + STEP;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- single-issue instruction fetch FSM.
//
// Sequence: FETCH issues one read at pc, WAIT counts MEM_LAT cycles and then
// captures the returned word into the instruction register, EXEC holds the
// instruction until exec_done, after which the FSM refetches sequentially,
// redirects to a branch target or stops in HALT (left only through reset).
//
// Ports:
//   clk            in   1       clock, all state changes on posedge
//   rst_n          in   1       synchronous active-low reset
//   mem_addr       out  ADDR_W  fetch address, meaningful while mem_rd=1
//   mem_rd         out  1       one-cycle read strobe per fetch
//   mem_rdata      in   DATA_W  read data, valid MEM_LAT cycles after mem_rd
//   stall          in   1       delays issue of the next fetch (FETCH only)
//   exec_done      in   1       execute stage finished the current instr
//   branch_valid   in   1       redirect request, qualified by exec_done
//   branch_target  in   ADDR_W  redirect address
//   halt           in   1       stop request, qualified by exec_done
//   instr          out  DATA_W  instruction register
//   instr_pc       out  ADDR_W  address instr was fetched from
//   instr_valid    out  1       high throughout EXEC
//   halted         out  1       high in HALT
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int                MEM_LAT     = DEF_MEM_LAT,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(DEF_RESET_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              exec_done,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    localparam int             CNT_W   = lat_cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_END = CNT_W'(MEM_LAT);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] instr_pc_reg;
    logic [CNT_W-1:0]  lat_cnt_reg;
    logic              instr_valid_reg;
    logic              halted_reg;

    logic              issue;
    logic              lat_hit;
    logic              take_branch;

    // The read strobe follows stall in the same cycle so a stalled FETCH
    // never issues; it is only ever high in FETCH.
    assign issue       = (state_reg == ST_FETCH) && !stall;
    assign lat_hit     = (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_END);
    // halt outranks branch_valid, so a halting instruction never redirects.
    assign take_branch = (state_reg == ST_EXEC) && exec_done && !halt && branch_valid;

    pc_unit #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_unit (
        .pc       (pc_reg),
        .advance  (lat_hit),
        .redirect (take_branch),
        .target   (branch_target),
        .pc_next  (pc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset also discards any read in flight: the WAIT state and its
            // counter are cleared, so late data is never captured.
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_ADDR;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            lat_cnt_reg     <= '0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            case (state_reg)
                ST_FETCH: begin
                    if (!stall) begin
                        state_reg   <= ST_WAIT;
                        lat_cnt_reg <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // stall has no effect here: the read is already issued.
                    if (lat_hit) begin
                        instr_reg       <= mem_rdata;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_EXEC;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        instr_valid_reg <= 1'b0;
                        if (halt) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    assign mem_rd      = issue;
    assign mem_addr    = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign halted      = halted_reg;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, address/PC width.
REQ-002 Parameter DATA_W, default 32, instruction/memory data width.
REQ-003 Parameter INSTR_BYTES, default 4, PC increment step; power of two, at least 1.
REQ-004 Parameter MEM_LAT, default 1, cycles from address issue to valid read data; at least 1.
REQ-005 Parameter RESET_ADDR, default 0, PC value after reset.
REQ-006 The module SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-007 clk  in  1  sole clock; all state updates on posedge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 mem_addr  out  ADDR_W  fetch address; valid only while mem_rd=1.
REQ-010 mem_rd  out  1  read request, one cycle per fetch.
REQ-011 mem_rdata  in  DATA_W  memory read data.
REQ-012 stall  in  1  holds issue of the next fetch.
REQ-013 exec_done  in  1  execute stage has finished the current instruction.
REQ-014 branch_valid  in  1  redirect request; qualified by exec_done.
REQ-015 branch_target  in  ADDR_W  redirect address.
REQ-016 halt  in  1  stop request; qualified by exec_done.
REQ-017 instr  out  DATA_W  instruction register.
REQ-018 instr_pc  out  ADDR_W  address the current instr was fetched from.
REQ-019 instr_valid  out  1  high throughout the EXEC state.
REQ-020 halted  out  1  high in the HALT state.

Function
REQ-021 The FSM SHALL have the states FETCH, WAIT, EXEC and HALT.
REQ-022 In FETCH with stall=0: mem_rd=1, mem_addr=pc, and the next state is WAIT, with the latency counter cleared to 1.
REQ-023 In FETCH with stall=1: mem_rd=0 and the FSM stays in FETCH.
REQ-024 In WAIT, stall SHALL be ignored and the counter SHALL increment each cycle.
REQ-025 When the counter equals MEM_LAT, the FSM SHALL capture mem_rdata into instr and pc into instr_pc, set pc to pc+INSTR_BYTES, and go to EXEC.
REQ-026 The pc increment SHALL wrap modulo 2^ADDR_W.
REQ-027 Fetch latency SHALL be: FETCH at cycle T, instr_valid=1 from cycle T+MEM_LAT+1.
REQ-028 EXEC SHALL hold until exec_done=1; instr and instr_pc SHALL remain stable in EXEC.
REQ-029 With exec_done=1 and halt=1, the next state SHALL be HALT; halt SHALL take priority over branch_valid.
REQ-030 With exec_done=1, halt=0 and branch_valid=1, pc SHALL become branch_target with its low log2(INSTR_BYTES) bits forced to 0, and the next state SHALL be FETCH.
REQ-031 With exec_done=1 and halt=branch_valid=0, the next state SHALL be FETCH with pc unchanged.
REQ-032 branch_valid and halt SHALL be ignored while exec_done=0 or outside EXEC.
REQ-033 HALT SHALL be left only through reset; in HALT, mem_rd=0 and instr_valid=0.
REQ-034 mem_rd SHALL never be high outside FETCH.

Reset
REQ-035 On a posedge with rst_n=0: state=FETCH, pc=RESET_ADDR, instr=0, instr_pc=0, counter=0, instr_valid=0, halted=0.
REQ-036 A reset asserted in any state, including mid-WAIT, SHALL abandon the in-flight fetch; late memory data SHALL NOT be captured.
REQ-037 The first cycle with rst_n=1 SHALL be a FETCH cycle at RESET_ADDR, unless stall=1.

Structure
REQ-038 The state encoding (2-bit enum) and the default-parameter constants SHALL live in a shared package, cpu_pkg.
REQ-039 PC next-value logic (increment, wrap, redirect, alignment) SHALL be one sub-module, pc_unit; the FSM and capture registers stay in fetch_sequencer.

Verification
REQ-040 Default parameters, reset release, memory word0=0xE3A00001, exec_done pulsed in the 2nd EXEC cycle -> mem_rd at cycle 0 with addr 0; instr=0xE3A00001 and instr_valid=1 at cycle 2; next fetch at addr 4.
REQ-041 MEM_LAT=3 -> instr_valid rises exactly 4 cycles after mem_rd; stall=1 during WAIT has no effect.
REQ-042 Branch: exec_done=1, branch_valid=1, branch_target=0x103 -> next mem_addr=0x100 and instr_pc=0x100 after capture.
REQ-043 pc=0xFFFFFFFC with a sequential fetch -> instr_pc=0xFFFFFFFC; next mem_addr=0x00000000.
REQ-044 Simultaneous halt=1 and branch_valid=1 with exec_done=1 -> halted=1, mem_rd stays 0 for 20 cycles; rst_n low for one cycle -> fetch resumes at RESET_ADDR.
REQ-045 rst_n=0 in the WAIT cycle with memory returning 0xDEADBEEF -> instr=0 and instr_valid=0 after reset; refetch occurs at RESET_ADDR.
